mm_stream_driver: RTL and testbench

Initiator side of the matrix-multiplier operand/result interface (CLK, START, A, B, OUT, OUT_STROBE).
- Holds a host-loaded 2x2 operand pair (8-bit unsigned elements).
- On GO, issues the START pulse and streams the element pairs to the multiplier.
- Captures the four 17-bit results returned on OUT_STROBE into a readable buffer.
- Replaces bench-driven stimulus with synthesizable control in front of the multiplier.

---
 rtl/mm_pkg.sv | 18 +
 rtl/mm_result_buf.sv | 27 ++
 rtl/mm_stream_driver.sv | 157 +++++++++++++++
 tb/tb_mm_stream_driver.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared sizes, load-address map and FSM states for the matrix-multiplier stream driver
package mm_pkg;

  localparam int N  = 2;
  localparam int NE = N * N;
  localparam int DW = 8;
  localparam int RW = 2 * DW + 1;

  localparam logic [2:0] A_BASE = 3'd0;
  localparam logic [2:0] B_BASE = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } mm_state_e;

endpackage

// File: rtl/mm_result_buf.sv
// rtl/mm_result_buf.sv - four-entry result register file with clear and combinational read
module mm_result_buf
  import mm_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          we_i,
  input  logic [1:0]    widx_i,
  input  logic [RW-1:0] wdata_i,
  input  logic [1:0]    raddr_i,
  output logic [RW-1:0] rdata_o
);

  logic [RW-1:0] mem_q [NE];

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < NE; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mm_stream_driver.sv
// rtl/mm_stream_driver.sv - loads a 2x2 operand pair, streams it to the multiplier and collects the results
module mm_stream_driver
  import mm_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LD_VALID,
  output logic          LD_READY,
  input  logic [2:0]    LD_ADDR,
  input  logic [DW-1:0] LD_DATA,
  input  logic          GO,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  input  logic [1:0]    RES_ADDR,
  output logic [RW-1:0] RES_DATA,
  output logic          MM_START,
  output logic [DW-1:0] MM_A,
  output logic [DW-1:0] MM_B,
  input  logic [RW-1:0] MM_OUT,
  input  logic          MM_OUT_STROBE
);

  localparam int TW = $clog2(TIMEOUT);

  mm_state_e     state_q, state_d;
  logic [DW-1:0] a_q [NE];
  logic [DW-1:0] a_d [NE];
  logic [DW-1:0] b_q [NE];
  logic [DW-1:0] b_d [NE];
  logic [1:0]    ecnt_q, ecnt_d;
  logic [2:0]    rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          mm_start_q, mm_start_d;
  logic [DW-1:0] mm_a_q, mm_a_d;
  logic [DW-1:0] mm_b_q, mm_b_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          buf_clr;

  logic ld_fire, go_fire, cap, last_cap;

  assign ld_fire  = LD_VALID && (state_q == IDLE);
  assign go_fire  = GO && (state_q == IDLE);
  assign cap      = MM_OUT_STROBE && (state_q != IDLE) && !rcnt_q[2];
  assign last_cap = cap && (rcnt_q == 3'd3);

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    state_d    = state_q;
    ecnt_d     = ecnt_q;
    rcnt_d     = rcnt_q;
    tcnt_d     = tcnt_q;
    mm_start_d = 1'b0;
    mm_a_d     = '0;
    mm_b_d     = '0;
    done_d     = last_cap;
    err_d      = err_q;
    buf_clr    = 1'b0;

    // Writes are applied first so a load in the GO cycle feeds element 0 directly.
    if (ld_fire && LD_ADDR < B_BASE) a_d[LD_ADDR[1:0]] = LD_DATA;
    if (ld_fire && LD_ADDR >= B_BASE) b_d[LD_ADDR[1:0]] = LD_DATA;

    if (cap) rcnt_d = rcnt_q + 3'd1;

    case (state_q)
      IDLE: begin
        if (go_fire) begin
          state_d    = SEND;
          mm_start_d = 1'b1;
          mm_a_d     = a_d[0];
          mm_b_d     = b_d[0];
          ecnt_d     = '0;
          rcnt_d     = '0;
          tcnt_d     = '0;
          err_d      = 1'b0;
          buf_clr    = 1'b1;
        end
      end
      SEND: begin
        if (ecnt_q == 2'd3) begin
          state_d = last_cap ? IDLE : WAIT;
          tcnt_d  = '0;
        end else begin
          mm_a_d = a_q[ecnt_q + 2'd1];
          mm_b_d = b_q[ecnt_q + 2'd1];
          ecnt_d = ecnt_q + 2'd1;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        // A capture in the same cycle as expiry takes priority over the timeout.
        if (last_cap) begin
          state_d = IDLE;
        end else if (tcnt_q == TW'(TIMEOUT - 2)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      for (int i = 0; i < NE; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      ecnt_q     <= '0;
      rcnt_q     <= '0;
      tcnt_q     <= '0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ecnt_q     <= ecnt_d;
      rcnt_q     <= rcnt_d;
      tcnt_q     <= tcnt_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  mm_result_buf u_buf (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (buf_clr),
    .we_i    (cap),
    .widx_i  (rcnt_q[1:0]),
    .wdata_i (MM_OUT),
    .raddr_i (RES_ADDR),
    .rdata_o (RES_DATA)
  );

  assign LD_READY = (state_q == IDLE);
  assign BUSY     = (state_q != IDLE);
  assign DONE     = done_q;
  assign ERR      = err_q;
  assign MM_START = mm_start_q;
  assign MM_A     = mm_a_q;
  assign MM_B     = mm_b_q;

endmodule

// File: tb/tb_mm_stream_driver.sv
// tb/tb_mm_stream_driver.sv - self-checking bench for mm_stream_driver with a behavioural multiplier
module tb_mm_stream_driver;

  localparam int TO = 64;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        LD_VALID = 1'b0;
  logic        LD_READY;
  logic [2:0]  LD_ADDR = '0;
  logic [7:0]  LD_DATA = '0;
  logic        GO = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [1:0]  RES_ADDR = '0;
  logic [16:0] RES_DATA;
  logic        MM_START;
  logic [7:0]  MM_A;
  logic [7:0]  MM_B;
  logic [16:0] MM_OUT = '0;
  logic        MM_OUT_STROBE = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int ea [4];
  int eb [4];

  always #5 CLK = ~CLK;

  mm_stream_driver #(.TIMEOUT(TO)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .LD_VALID      (LD_VALID),
    .LD_READY      (LD_READY),
    .LD_ADDR       (LD_ADDR),
    .LD_DATA       (LD_DATA),
    .GO            (GO),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .ERR           (ERR),
    .RES_ADDR      (RES_ADDR),
    .RES_DATA      (RES_DATA),
    .MM_START      (MM_START),
    .MM_A          (MM_A),
    .MM_B          (MM_B),
    .MM_OUT        (MM_OUT),
    .MM_OUT_STROBE (MM_OUT_STROBE)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input int data);
    @(negedge CLK);
    LD_VALID = 1'b1;
    LD_ADDR  = addr[2:0];
    LD_DATA  = data[7:0];
    if (addr < 4) ea[addr] = data;
    else eb[addr - 4] = data;
    @(negedge CLK);
    LD_VALID = 1'b0;
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) load(i, $urandom_range(0, 255));
  endtask

  // One GO transaction; the multiplier answers with nstr strobes starting 3 cycles after the last element.
  task automatic run(input int nstr, input bit wr_with_go, input bit busy_write, input bit go_in_wait);
    int c_exp [4];
    int done_n, done_at, err_at;
    @(negedge CLK);
    GO = 1'b1;
    if (wr_with_go) begin
      LD_VALID = 1'b1;
      LD_ADDR  = 3'd0;
      LD_DATA  = 8'd7;
      ea[0]    = 7;
    end
    c_exp[0] = ea[0] * eb[0] + ea[1] * eb[2];
    c_exp[1] = ea[0] * eb[1] + ea[1] * eb[3];
    c_exp[2] = ea[2] * eb[0] + ea[3] * eb[2];
    c_exp[3] = ea[2] * eb[1] + ea[3] * eb[3];
    done_n = 0;
    done_at = -1;
    err_at = -1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge CLK);
      GO = 1'b0;
      LD_VALID = 1'b0;
      MM_OUT_STROBE = 1'b0;
      MM_OUT = '0;
      if (c == 1) chk("err_clear_on_go", ERR, 0);
      if (c >= 1 && c <= 4) begin
        chk("mm_start", MM_START, (c == 1) ? 1 : 0);
        chk("mm_a", MM_A, ea[c - 1]);
        chk("mm_b", MM_B, eb[c - 1]);
        chk("busy_send", BUSY, 1);
      end
      if (c == 5) begin
        chk("mm_a_idle", MM_A, 0);
        chk("mm_b_idle", MM_B, 0);
        chk("mm_start_idle", MM_START, 0);
      end
      if (DONE) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
      if (ERR && err_at < 0) err_at = c;
      if (c >= 7 && c - 7 < nstr) begin
        MM_OUT_STROBE = 1'b1;
        MM_OUT = (c - 7 < 4) ? c_exp[c - 7][16:0] : 17'h1ABCD;
      end
      if (busy_write && c == 6) begin
        chk("ld_ready_busy", LD_READY, 0);
        LD_VALID = 1'b1;
        LD_ADDR  = 3'd0;
        LD_DATA  = 8'd9;
      end
      if (go_in_wait && c == 8) GO = 1'b1;
    end
    chk("busy_end", BUSY, 0);
    chk("ld_ready_end", LD_READY, 1);
    if (nstr >= 4) begin
      chk("done_count", done_n, 1);
      chk("done_cycle", done_at, 11);
      chk("err_none", err_at, 32'hFFFF_FFFF);
    end else begin
      chk("done_none", done_n, 0);
      chk("err_cycle", err_at, 5 + TO - 1);
    end
    for (int i = 0; i < 4; i++) begin
      RES_ADDR = 2'(i);
      #1;
      chk("res_data", RES_DATA, (i < nstr) ? c_exp[i] : 0);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ea[i] = 0;
      eb[i] = 0;
    end
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ld_ready", LD_READY, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR, 0);
    chk("rst_mm_start", MM_START, 0);
    chk("rst_mm_a", MM_A, 0);
    chk("rst_mm_b", MM_B, 0);
    for (int i = 0; i < 4; i++) begin
      RES_ADDR = 2'(i);
      #1;
      chk("rst_res", RES_DATA, 0);
    end

    for (int i = 0; i < 4; i++) load(i, i + 1);
    for (int i = 0; i < 4; i++) load(4 + i, i + 5);
    run(4, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) load(i, 255);
    run(4, 1'b0, 1'b0, 1'b0);

    load_random();
    run(3, 1'b0, 1'b0, 1'b0);
    load_random();
    run(4, 1'b0, 1'b0, 1'b0);

    load_random();
    run(4, 1'b0, 1'b1, 1'b1);
    run(4, 1'b0, 1'b0, 1'b0);

    load_random();
    run(5, 1'b1, 1'b0, 1'b0);

    load_random();
    @(negedge CLK);
    GO = 1'b1;
    @(negedge CLK);
    GO = 1'b0;
    chk("pre_rst_start", MM_START, 1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_start", MM_START, 0);
    chk("mid_rst_a", MM_A, 0);
    chk("mid_rst_b", MM_B, 0);
    chk("mid_rst_ld_ready", LD_READY, 1);
    chk("mid_rst_done", DONE, 0);
    for (int i = 0; i < 4; i++) begin
      ea[i] = 0;
      eb[i] = 0;
    end
    run(4, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      load_random();
      run(4, 1'b0, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
